// File: rtl/universal_shift_reg_pkg.sv
// Shared constants for the universal shift register: operation codes,
// FSM state encoding and the shift-mode classifier.
package shift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // Only the shift/rotate codes may start a burst.
   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ASR);
   endfunction

endpackage

// File: rtl/universal_shift_reg_shift_step.sv
// Combinational next-value unit: computes the register contents after one
// step of the selected operation. Shared by single-step and burst paths.
module shift_step
   import shift_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic [2:0]      mode,
   input  logic [SIZE-1:0] q,
   input  logic [SIZE-1:0] d,
   input  logic            ser_in_l,
   input  logic            ser_in_r,
   output logic [SIZE-1:0] next_q
);

   always_comb begin
      next_q = q;
      case (mode)
         MODE_HOLD: next_q = q;
         MODE_LOAD: next_q = d;
         MODE_SHL:  next_q = {q[SIZE-2:0], ser_in_r};
         MODE_SHR:  next_q = {ser_in_l, q[SIZE-1:1]};
         MODE_ROL:  next_q = {q[SIZE-2:0], q[SIZE-1]};
         MODE_ROR:  next_q = {q[0], q[SIZE-1:1]};
         MODE_ASR:  next_q = {q[SIZE-1], q[SIZE-1:1]};
         MODE_CLR:  next_q = '0;
         default:   next_q = q;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-step operations and a counted burst
// mode that repeats one latched shift for N consecutive edges.
module universal_shift_reg
   import shift_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [SIZE-1:0]  d,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [SIZE-1:0]  q,
   output logic             ser_out_l,
   output logic             ser_out_r,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic [0:0]       state_reg, state_next;
   logic [CNT_W-1:0] remaining_reg, remaining_next;
   logic [2:0]       burst_mode_reg, burst_mode_next;
   logic [SIZE-1:0]  q_reg, q_next;
   logic             done_reg, done_next;

   logic [2:0]       step_mode;
   logic [SIZE-1:0]  step_q;

   // While bursting, the latched mode drives the step unit and live mode is ignored.
   assign step_mode = (state_reg == ST_BURST) ? burst_mode_reg : mode;

   shift_step #(
      .SIZE(SIZE)
   ) u_step (
      .mode    (step_mode),
      .q       (q_reg),
      .d       (d),
      .ser_in_l(ser_in_l),
      .ser_in_r(ser_in_r),
      .next_q  (step_q)
   );

   always_comb begin
      state_next      = state_reg;
      remaining_next  = remaining_reg;
      burst_mode_next = burst_mode_reg;
      q_next          = q_reg;
      done_next       = 1'b0;

      if (state_reg == ST_IDLE) begin
         if (start && is_shift_mode(mode)) begin
            if (count == CNT_ZERO) begin
               // Zero-length burst: nothing shifts, but the requester still gets done.
               done_next = 1'b1;
            end else begin
               q_next          = step_q;
               burst_mode_next = mode;
               if (count == CNT_ONE) begin
                  done_next = 1'b1;
               end else begin
                  state_next     = ST_BURST;
                  remaining_next = count - CNT_ONE;
               end
            end
         end else begin
            q_next = step_q;
         end
      end else begin
         q_next         = step_q;
         remaining_next = remaining_reg - CNT_ONE;
         if (remaining_reg == CNT_ONE) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         remaining_reg  <= '0;
         burst_mode_reg <= MODE_HOLD;
         q_reg          <= '0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         remaining_reg  <= remaining_next;
         burst_mode_reg <= burst_mode_next;
         q_reg          <= q_next;
         done_reg       <= done_next;
      end
   end

   assign q         = q_reg;
   assign ser_out_l = q_reg[SIZE-1];
   assign ser_out_r = q_reg[0];
   assign busy      = (state_reg == ST_BURST);
   assign done      = done_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed testbench for universal_shift_reg (SIZE=8, CNT_W=4): single steps,
// bursts, edge cases, back-to-back bursts and reset during a burst.
module tb_universal_shift_reg;
   import shift_pkg::*;

   localparam int SIZE  = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       mode;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [SIZE-1:0]  d;
   logic             ser_in_l;
   logic             ser_in_r;
   logic [SIZE-1:0]  q;
   logic             ser_out_l;
   logic             ser_out_r;
   logic             busy;
   logic             done;

   int tests_run    = 0;
   int tests_failed = 0;

   universal_shift_reg #(
      .SIZE (SIZE),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .mode     (mode),
      .start    (start),
      .count    (count),
      .d        (d),
      .ser_in_l (ser_in_l),
      .ser_in_r (ser_in_r),
      .q        (q),
      .ser_out_l(ser_out_l),
      .ser_out_r(ser_out_r),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Advance one active edge and land 1 time unit after it for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_value(input logic [SIZE-1:0] v);
      start = 1'b0;
      mode  = MODE_LOAD;
      d     = v;
      tick();
      mode  = MODE_HOLD;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tests_run++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: q=%h busy=%b done=%b required q=00 busy=0 done=0", q, busy, done);
      end
      reset = 1'b0;
      $display("[TB] reset q=%h busy=%b done=%b", q, busy, done);
   endtask

   task automatic test_load_hold();
      load_value(8'hA5);
      tests_run++;
      if (q !== 8'hA5) begin
         tests_failed++;
         $display("FAIL load: q=%h required a5", q);
      end
      $display("[TB] load q=%h", q);
      for (int i = 0; i < 3; i++) begin
         mode = MODE_HOLD;
         tick();
         tests_run++;
         if (q !== 8'hA5 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold%0d: q=%h done=%b required q=a5 done=0", i, q, done);
         end
         $display("[TB] hold%0d q=%h", i, q);
      end
   endtask

   task automatic test_single_steps();
      logic [2:0]      m_tab [6];
      logic [SIZE-1:0] e_tab [6];
      m_tab = '{MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR};
      e_tab = '{8'h03, 8'h40, 8'h03, 8'hC0, 8'hC0, 8'h00};
      for (int i = 0; i < 6; i++) begin
         load_value(8'h81);
         ser_in_r = 1'b1;
         ser_in_l = 1'b0;
         mode     = m_tab[i];
         start    = 1'b0;
         tick();
         tests_run++;
         if (q !== e_tab[i] || ser_out_l !== e_tab[i][7] || ser_out_r !== e_tab[i][0] || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_mode%0d: q=%h sol=%b sor=%b done=%b required q=%h done=0",
                     m_tab[i], q, ser_out_l, ser_out_r, done, e_tab[i]);
         end
         $display("[TB] step mode=%0d q=%h", m_tab[i], q);
      end
      mode = MODE_HOLD;
   endtask

   task automatic test_burst_rol();
      int busy_cycles;
      busy_cycles = 0;
      load_value(8'h96);
      start = 1'b1;
      mode  = MODE_ROL;
      count = 4'd8;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         // Garbage on mode/d must not disturb the burst.
         mode = (i % 2 == 1) ? MODE_CLR : MODE_LOAD;
         d    = 8'hFF;
         if (busy === 1'b1) busy_cycles++;
         tests_run++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rol_busy%0d: busy=%b done=%b required busy=1 done=0", i, busy, done);
         end
         if (i == 4) begin
            tests_run++;
            if (q !== 8'h69) begin
               tests_failed++;
               $display("FAIL rol_mid: q=%h required 69", q);
            end
         end
         tick();
      end
      tests_run++;
      if (busy_cycles != 7) begin
         tests_failed++;
         $display("FAIL rol_busy_count: %0d required 7", busy_cycles);
      end
      tests_run++;
      if (q !== 8'h96 || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL rol_end: q=%h busy=%b done=%b required q=96 busy=0 done=1", q, busy, done);
      end
      $display("[TB] burst rol q=%h busy_cycles=%0d done=%b", q, busy_cycles, done);
      mode = MODE_HOLD;
      tick();
      tests_run++;
      if (q !== 8'h96 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL rol_after: q=%h done=%b required q=96 done=0", q, done);
      end
   endtask

   task automatic test_burst_deser();
      logic            bits [8];
      logic [SIZE-1:0] exp_q;
      bits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      mode  = MODE_CLR;
      start = 1'b0;
      tick();
      exp_q = 8'h00;
      start = 1'b1;
      mode  = MODE_SHR;
      count = 4'd8;
      for (int i = 0; i < 8; i++) begin
         ser_in_l = bits[i];
         tick();
         start = 1'b0;
         mode  = MODE_HOLD;
         exp_q = {bits[i], exp_q[7:1]};
         tests_run++;
         if (q !== exp_q || ser_out_r !== exp_q[0] || ser_out_l !== exp_q[7]) begin
            tests_failed++;
            $display("FAIL deser_bit%0d: q=%h sor=%b sol=%b required q=%h", i, q, ser_out_r, ser_out_l, exp_q);
         end
         $display("[TB] deser bit%0d in=%b q=%h ser_out_r=%b", i, bits[i], q, ser_out_r);
      end
      tests_run++;
      if (q !== 8'h4D || done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL deser_end: q=%h done=%b busy=%b required q=4d done=1 busy=0", q, done, busy);
      end
      tick();
   endtask

   task automatic test_edge_cases();
      // count = 0
      load_value(8'h3C);
      start = 1'b1;
      mode  = MODE_SHL;
      count = 4'd0;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL count0: q=%h busy=%b done=%b required q=3c busy=0 done=1", q, busy, done);
      end
      $display("[TB] count0 q=%h done=%b", q, done);
      tick();
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL count0_pulse: done=%b required 0", done);
      end
      // count = 1
      start    = 1'b1;
      mode     = MODE_SHR;
      count    = 4'd1;
      ser_in_l = 1'b1;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'h9E || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL count1: q=%h busy=%b done=%b required q=9e busy=0 done=1", q, busy, done);
      end
      $display("[TB] count1 q=%h done=%b", q, done);
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL count1_after: done=%b busy=%b required 0 0", done, busy);
      end
      // start with a non-shift mode
      start = 1'b1;
      mode  = MODE_LOAD;
      d     = 8'h55;
      count = 4'd5;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'h55 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_load: q=%h busy=%b done=%b required q=55 busy=0 done=0", q, busy, done);
      end
      tick();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_load_after: busy=%b done=%b required 0 0", busy, done);
      end
      $display("[TB] start_load q=%h", q);
   endtask

   task automatic test_back_to_back();
      load_value(8'h55);
      start = 1'b1;
      mode  = MODE_ROR;
      count = 4'd2;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'hAA || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_first1: q=%h busy=%b required q=aa busy=1", q, busy);
      end
      tick();
      tests_run++;
      if (q !== 8'h55 || done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_first_done: q=%h done=%b busy=%b required q=55 done=1 busy=0", q, done, busy);
      end
      // Restart in the done cycle.
      start = 1'b1;
      mode  = MODE_ROL;
      count = 4'd3;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'hAA || busy !== 1'b1 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_second1: q=%h busy=%b done=%b required q=aa busy=1 done=0", q, busy, done);
      end
      tick();
      tests_run++;
      if (q !== 8'h55 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_second2: q=%h busy=%b required q=55 busy=1", q, busy);
      end
      tick();
      tests_run++;
      if (q !== 8'hAA || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_second_done: q=%h busy=%b done=%b required q=aa busy=0 done=1", q, busy, done);
      end
      $display("[TB] back_to_back q=%h done=%b", q, done);
      tick();
   endtask

   task automatic test_reset_mid_burst();
      int done_seen;
      done_seen = 0;
      load_value(8'h01);
      start    = 1'b1;
      mode     = MODE_SHL;
      count    = 4'd10;
      ser_in_r = 1'b0;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tick();
      tick();
      tests_run++;
      if (q !== 8'h08 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_pre: q=%h busy=%b required q=08 busy=1", q, busy);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst: q=%h busy=%b done=%b required q=00 busy=0 done=0", q, busy, done);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      tests_run++;
      if (done_seen != 0) begin
         tests_failed++;
         $display("FAIL midrst_quiet: %0d cycles with done/busy, required 0", done_seen);
      end
      start    = 1'b1;
      mode     = MODE_SHL;
      count    = 4'd2;
      ser_in_r = 1'b1;
      tick();
      start = 1'b0;
      mode  = MODE_HOLD;
      tests_run++;
      if (q !== 8'h01 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_restart1: q=%h busy=%b required q=01 busy=1", q, busy);
      end
      tick();
      tests_run++;
      if (q !== 8'h03 || busy !== 1'b0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_restart2: q=%h busy=%b done=%b required q=03 busy=0 done=1", q, busy, done);
      end
      $display("[TB] reset_mid_burst restart q=%h done=%b", q, done);
   endtask

   initial begin
      reset    = 1'b1;
      mode     = MODE_HOLD;
      start    = 1'b0;
      count    = '0;
      d        = '0;
      ser_in_l = 1'b0;
      ser_in_r = 1'b0;
      test_reset();
      test_load_hold();
      test_single_steps();
      test_burst_rol();
      test_burst_deser();
      test_edge_cases();
      test_back_to_back();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
